time_param_bank: RTL and testbench

//  Programmable bank of traffic-light interval lengths (tBASE, tEXT, tYEL, tWALK) with an integrated countdown timer.

---
 rtl/tlc_pkg.sv | 26 ++
 rtl/time_param_bank_if.sv | 31 +++
 rtl/time_param_countdown.sv | 50 +++++
 rtl/time_param_bank.sv | 99 +++++++++
 tb/tb_time_param_bank.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/tlc_pkg.sv
// Shared traffic-light controller constants: interval indices, default
// interval lengths and bank geometry, used by the parameter bank and the FSM.
package tlc_pkg;

    // Interval indices into the parameter bank.
    localparam int IDX_BASE = 0;
    localparam int IDX_EXT  = 1;
    localparam int IDX_YEL  = 2;
    localparam int IDX_WALK = 3;

    // Bank geometry defaults.
    localparam int N_PARAMS_DEF = 4;
    localparam int VAL_W_DEF    = 4;
    localparam int SEL_W_DEF    = $clog2(N_PARAMS_DEF);

    // Default interval lengths in ticks.
    localparam logic [VAL_W_DEF-1:0] T_BASE_DEF = 4'd6;
    localparam logic [VAL_W_DEF-1:0] T_EXT_DEF  = 4'd3;
    localparam logic [VAL_W_DEF-1:0] T_YEL_DEF  = 4'd2;
    localparam logic [VAL_W_DEF-1:0] T_WALK_DEF = 4'd3;

    // Packed reset image; entry i lives at [i*VAL_W +: VAL_W].
    localparam logic [N_PARAMS_DEF*VAL_W_DEF-1:0] DEFAULTS_DEF =
        {T_WALK_DEF, T_YEL_DEF, T_EXT_DEF, T_BASE_DEF};

endpackage

// File: rtl/time_param_bank_if.sv
// Bus between the sequencing FSM / synchronisers (master) and the
// interval parameter bank with its countdown timer (slave).
interface time_param_bank_if #(
    parameter int VAL_W = 4,
    parameter int SEL_W = 2
);
    logic             Reset_Sync;
    logic             Prog_Sync;
    logic [SEL_W-1:0] Time_Parameter_Selector;
    logic [VAL_W-1:0] Time_value;
    logic [SEL_W-1:0] interval;
    logic             Start_Timer;
    logic             Tick;
    logic [VAL_W-1:0] value;
    logic [VAL_W-1:0] Remaining;
    logic             Busy;
    logic             Expired;
    logic             Prog_Err;

    modport master (
        output Reset_Sync, Prog_Sync, Time_Parameter_Selector, Time_value,
        output interval, Start_Timer, Tick,
        input  value, Remaining, Busy, Expired, Prog_Err
    );

    modport slave (
        input  Reset_Sync, Prog_Sync, Time_Parameter_Selector, Time_value,
        input  interval, Start_Timer, Tick,
        output value, Remaining, Busy, Expired, Prog_Err
    );
endinterface

// File: rtl/time_param_countdown.sv
// Interval countdown: clear > load > tick priority, saturates at zero and
// emits a one-cycle Expired pulse when a tick takes the count from 1 to 0.
module time_param_countdown #(
    parameter int VAL_W = 4
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [VAL_W-1:0] load_val,
    input  logic             Tick,
    output logic [VAL_W-1:0] Remaining,
    output logic             Busy,
    output logic             Expired
);
    logic [VAL_W-1:0] remaining_q, remaining_d;
    logic             expired_q, expired_d;

    // Next count and expiry pulse, by clear/load/tick priority.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        remaining_d = remaining_q;
        expired_d   = 1'b0;
        if (clear) begin
            remaining_d = '0;
        end else if (load) begin
            remaining_d = load_val;
        end else if (Tick && (remaining_q != '0)) begin
            remaining_d = remaining_q - VAL_W'(1);
            expired_d   = (remaining_q == VAL_W'(1));
        end
    end

    // Count and pulse registers.
    always_ff @(posedge clk or negedge Reset_n) begin
        // NOTE: non-blocking assignments so all flops update from pre-edge values.
        if (!Reset_n) begin
            remaining_q <= '0;
            expired_q   <= 1'b0;
        end else begin
            remaining_q <= remaining_d;
            expired_q   <= expired_d;
        end
    end

    assign Remaining = remaining_q;
    assign Busy      = (remaining_q != '0);
    assign Expired   = expired_q;

endmodule

// File: rtl/time_param_bank.sv
// Programmable bank of traffic-light interval lengths with write-legality
// checking, a zero-padded read mux and an integrated countdown timer.
module time_param_bank
    import tlc_pkg::*;
#(
    parameter int                          N_PARAMS = N_PARAMS_DEF,
    parameter int                          VAL_W    = VAL_W_DEF,
    parameter int                          SEL_W    = $clog2(N_PARAMS),
    parameter logic [N_PARAMS*VAL_W-1:0]   DEFAULTS = DEFAULTS_DEF
) (
    input  logic             clk,
    input  logic             Reset_n,
    time_param_bank_if.slave bus
);
    // Selector space may exceed the bank; unused slots read as 0 and reject writes.
    localparam int N_SLOTS = 1 << SEL_W;

    logic [VAL_W-1:0]   bank_q [N_PARAMS];
    logic [VAL_W-1:0]   bank_d [N_PARAMS];
    logic               prog_err_q, prog_err_d;
    logic [N_SLOTS-1:0] sel_ok_tbl;
    logic [VAL_W-1:0]   rd_tbl [N_SLOTS];
    logic               wr_ok;
    logic [VAL_W-1:0]   rd_val;

    // Slot tables: which selectors address a real entry, and what each slot reads.
    always_comb begin
        sel_ok_tbl = '0;
        rd_tbl     = '{default: '0};
        for (int i = 0; i < N_PARAMS; i++) begin
            sel_ok_tbl[i] = 1'b1;
            rd_tbl[i]     = bank_q[i];
        end
    end

    assign rd_val = rd_tbl[bus.interval];
    assign wr_ok  = sel_ok_tbl[bus.Time_Parameter_Selector] && (bus.Time_value != '0);

    // Bank update: restore defaults beats programming; illegal writes flag an error.
    always_comb begin
        bank_d     = bank_q;
        prog_err_d = 1'b0;
        if (bus.Reset_Sync) begin
            for (int i = 0; i < N_PARAMS; i++) begin
                bank_d[i] = DEFAULTS[i*VAL_W +: VAL_W];
            end
        end else if (bus.Prog_Sync) begin
            if (wr_ok) begin
                for (int i = 0; i < N_PARAMS; i++) begin
                    if (bus.Time_Parameter_Selector == SEL_W'(i)) begin
                        bank_d[i] = bus.Time_value;
                    end
                end
            end else begin
                prog_err_d = 1'b1;
            end
        end
    end

    // Bank and error-pulse registers.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            // NOTE: the bank is a handful of flops, not RAM, so it can carry per-entry reset values.
            for (int i = 0; i < N_PARAMS; i++) begin
                bank_q[i] <= DEFAULTS[i*VAL_W +: VAL_W];
            end
            prog_err_q <= 1'b0;
        end else begin
            bank_q     <= bank_d;
            prog_err_q <= prog_err_d;
        end
    end

    logic [VAL_W-1:0] cd_remaining;
    logic             cd_busy;
    logic             cd_expired;

    // Start_Timer loads the pre-edge bank contents through the read mux.
    time_param_countdown #(
        .VAL_W (VAL_W)
    ) u_countdown (
        .clk       (clk),
        .Reset_n   (Reset_n),
        .clear     (bus.Reset_Sync),
        .load      (bus.Start_Timer),
        .load_val  (rd_val),
        .Tick      (bus.Tick),
        .Remaining (cd_remaining),
        .Busy      (cd_busy),
        .Expired   (cd_expired)
    );

    assign bus.value     = rd_val;
    assign bus.Remaining = cd_remaining;
    assign bus.Busy      = cd_busy;
    assign bus.Expired   = cd_expired;
    assign bus.Prog_Err  = prog_err_q;

endmodule

// File: tb/tb_time_param_bank.sv
// Directed, table-driven bench for time_param_bank: bank reset/programming,
// write rejection, countdown sequencing and asynchronous reset mid-count.
module tb_time_param_bank;
    import tlc_pkg::*;

    logic clk;
    logic Reset_n;
    int   checks;
    int   errors;

    time_param_bank_if #(.VAL_W(4), .SEL_W(2)) bus ();

    time_param_bank #(
        .N_PARAMS (4),
        .VAL_W    (4),
        .SEL_W    (2),
        .DEFAULTS (16'h3236)
    ) dut (
        .clk     (clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic       pg;
        logic [1:0] sel;
        logic [3:0] tv;
        logic [1:0] iv;
        logic       st;
        logic       tk;
        logic [3:0] e_val;
        logic [3:0] e_rem;
        logic       e_exp;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int rs, input int pg, input int sel, input int tv,
                                input int iv, input int st, input int tk,
                                input int ev, input int er, input int ex, input int ee);
        vec_t v;
        v.rs    = 1'(rs);
        v.pg    = 1'(pg);
        v.sel   = 2'(sel);
        v.tv    = 4'(tv);
        v.iv    = 2'(iv);
        v.st    = 1'(st);
        v.tk    = 1'(tk);
        v.e_val = 4'(ev);
        v.e_rem = 4'(er);
        v.e_exp = 1'(ex);
        v.e_err = 1'(ee);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.Reset_Sync              = 1'b0;
        bus.Prog_Sync               = 1'b0;
        bus.Time_Parameter_Selector = 2'd0;
        bus.Time_value              = 4'd0;
        bus.interval                = 2'd0;
        bus.Start_Timer             = 1'b0;
        bus.Tick                    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        Reset_n = 1'b0;
        idle_inputs();

        // Reset state while Reset_n is held low.
        #12;
        check("rst value0", 32'(bus.value), 6);
        check("rst remaining", 32'(bus.Remaining), 0);
        check("rst busy", 32'(bus.Busy), 0);
        check("rst expired", 32'(bus.Expired), 0);
        check("rst prog_err", 32'(bus.Prog_Err), 0);
        @(negedge clk);
        Reset_n = 1'b1;
        step();

        //                rs pg sel        tv  iv        st tk  val rem exp err
        vecs.push_back(mk(0, 0, 0,         0,  IDX_BASE, 0, 0,  6,  0,  0,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_EXT,  0, 0,  3,  0,  0,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_YEL,  0, 0,  2,  0,  0,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_WALK, 0, 0,  3,  0,  0,  0));
        vecs.push_back(mk(0, 1, IDX_EXT,   4,  IDX_EXT,  0, 0,  4,  0,  0,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_BASE, 0, 0,  6,  0,  0,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_YEL,  0, 0,  2,  0,  0,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_WALK, 0, 0,  3,  0,  0,  0));
        vecs.push_back(mk(0, 1, IDX_YEL,   0,  IDX_YEL,  0, 0,  2,  0,  0,  1));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_YEL,  0, 0,  2,  0,  0,  0));
        vecs.push_back(mk(0, 1, IDX_WALK,  15, IDX_WALK, 0, 0,  15, 0,  0,  0));
        vecs.push_back(mk(1, 1, IDX_YEL,   0,  IDX_EXT,  0, 0,  3,  0,  0,  0));
        vecs.push_back(mk(1, 1, IDX_WALK,  7,  IDX_WALK, 0, 0,  3,  0,  0,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_YEL,  1, 0,  2,  2,  0,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_YEL,  0, 1,  2,  1,  0,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_YEL,  0, 1,  2,  0,  1,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_YEL,  0, 1,  2,  0,  0,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_YEL,  0, 1,  2,  0,  0,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_BASE, 1, 0,  6,  6,  0,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_BASE, 0, 1,  6,  5,  0,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_BASE, 0, 1,  6,  4,  0,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_BASE, 0, 1,  6,  3,  0,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_BASE, 1, 1,  6,  6,  0,  0));
        vecs.push_back(mk(0, 1, IDX_BASE,  9,  IDX_BASE, 0, 1,  9,  5,  0,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_BASE, 0, 1,  9,  4,  0,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_BASE, 0, 1,  9,  3,  0,  0));
        vecs.push_back(mk(1, 0, 0,         0,  IDX_BASE, 0, 0,  6,  0,  0,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_BASE, 0, 0,  6,  0,  0,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_YEL,  1, 0,  2,  2,  0,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_YEL,  0, 1,  2,  1,  0,  0));
        vecs.push_back(mk(1, 0, 0,         0,  IDX_YEL,  0, 1,  2,  0,  0,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_YEL,  0, 0,  2,  0,  0,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_WALK, 1, 0,  3,  3,  0,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_YEL,  1, 0,  2,  2,  0,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_YEL,  0, 1,  2,  1,  0,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_YEL,  0, 1,  2,  0,  1,  0));
        vecs.push_back(mk(0, 0, 0,         0,  IDX_YEL,  0, 0,  2,  0,  0,  0));

        foreach (vecs[i]) begin
            bus.Reset_Sync              = vecs[i].rs;
            bus.Prog_Sync               = vecs[i].pg;
            bus.Time_Parameter_Selector = vecs[i].sel;
            bus.Time_value              = vecs[i].tv;
            bus.interval                = vecs[i].iv;
            bus.Start_Timer             = vecs[i].st;
            bus.Tick                    = vecs[i].tk;
            step();
            check($sformatf("v%0d value", i), 32'(bus.value), int'(vecs[i].e_val));
            check($sformatf("v%0d remaining", i), 32'(bus.Remaining), int'(vecs[i].e_rem));
            check($sformatf("v%0d busy", i), 32'(bus.Busy), (vecs[i].e_rem != 4'd0) ? 1 : 0);
            check($sformatf("v%0d expired", i), 32'(bus.Expired), int'(vecs[i].e_exp));
            check($sformatf("v%0d prog_err", i), 32'(bus.Prog_Err), int'(vecs[i].e_err));
        end
        idle_inputs();

        // Asynchronous Reset_n in the middle of a count with a pending Prog_Err.
        bus.Prog_Sync               = 1'b1;
        bus.Time_Parameter_Selector = 2'(IDX_BASE);
        bus.Time_value              = 4'd9;
        step();
        check("async prog value0", 32'(bus.value), 9);
        bus.Prog_Sync   = 1'b0;
        bus.Start_Timer = 1'b1;
        step();
        check("async load remaining", 32'(bus.Remaining), 9);
        bus.Start_Timer             = 1'b0;
        bus.Tick                    = 1'b1;
        bus.Prog_Sync               = 1'b1;
        bus.Time_Parameter_Selector = 2'(IDX_EXT);
        bus.Time_value              = 4'd0;
        step();
        check("async pre remaining", 32'(bus.Remaining), 8);
        check("async pre prog_err", 32'(bus.Prog_Err), 1);
        idle_inputs();
        #2;
        Reset_n = 1'b0;
        #1;
        check("async remaining", 32'(bus.Remaining), 0);
        check("async busy", 32'(bus.Busy), 0);
        check("async expired", 32'(bus.Expired), 0);
        check("async prog_err", 32'(bus.Prog_Err), 0);
        check("async value0", 32'(bus.value), 6);
        @(negedge clk);
        Reset_n = 1'b1;
        step();
        check("post value0", 32'(bus.value), 6);
        check("post remaining", 32'(bus.Remaining), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
